sdspihost_bram_responder: RTL and testbench
===========================================

Name: sdspihost_bram_responder

Overview:
- Device-side responder for the SD SPI host byte/block handshake that the autotest FSMs drive (busy, r_block/r_byte, w_block/w_byte, rst, block_addr, data_in/out, err, crc_err).
- Backs the card with on-chip BRAM so the autotest cores run in simulation and on FPGA without an SD card.
- Instantiated in place of the SD SPI host; a backdoor port preloads test vectors and dumps results.

Parameters:
- BLK_ADDR_W, 4: log2 of emulated block count (16 blocks × 512 B).
- BASE_BLOCK, 32'h0010_0000: first valid block_addr.
- INIT_CYCLES, 100: busy duration after spi_rst.
- BLOCK_LATENCY, 8: busy duration on block open (read or write).
- BYTE_LATENCY, 2: busy duration per byte; minimum 2.
- COMMIT_LATENCY, 16: busy duration after write block close.

Ports:
- clk  in  1  clock.
- rst  in  1  reset (synchronous, active-high).
- spi_rst  in  1  card init request.
- spi_block_addr  in  32  block address, latched at block open.
- spi_r_block  in  1  read-block session request (level).
- spi_r_byte  in  1  next read byte request.
- spi_w_block  in  1  write-block session request (level).
- spi_w_byte  in  1  write byte request.
- spi_data_in  in  8  write data.
- spi_data_out  out  8  current read byte.
- spi_busy  out  1  responder busy.
- spi_err  out  1  sticky error: out-of-range block, or access before init.
- spi_crc_err  out  1  pulse at end of a read byte when crc_inject=1.
- crc_inject  in  1  test hook.
- bd_we  in  1  backdoor write strobe.
- bd_addr  in  BLK_ADDR_W+9  backdoor byte address.
- bd_din  in  8  backdoor write data.
- bd_dout  out  8  backdoor read data, one-cycle latency.

Behaviour:
- Reset values: spi_busy=0, spi_data_out=8'hFF, spi_err=0, spi_crc_err=0, bd_dout=0. State S_UNINIT; offset=0; latency counter=0.
- States: S_UNINIT, S_INIT, S_IDLE, S_RB_LOAD, S_RB_READY, S_RB_BYTE, S_WB_OPEN, S_WB_READY, S_WB_BYTE, S_WB_COMMIT.
- spi_rst high in any state:
  - Go to S_INIT next cycle with busy=1 and spi_err cleared.
  - Any open session is aborted; bytes already written stay in memory.
- S_INIT: busy=1 for INIT_CYCLES. Then go to S_IDLE only once spi_rst=0; otherwise hold busy.
- S_UNINIT:
  - busy=0.
  - r_block or w_block sets spi_err=1 and is ignored.
- S_IDLE: busy=0. Latch blk = spi_block_addr - BASE_BLOCK and set offset=0.
  - r_block: go to S_RB_LOAD.
  - w_block: go to S_WB_OPEN.
  - Both high: read wins.
  - Out of range (blk ≥ 2^BLK_ADDR_W or spi_block_addr < BASE_BLOCK): spi_err=1, session still runs, reads return 8'hFF, writes are dropped.
- S_RB_LOAD:
  - busy=1 for BLOCK_LATENCY and fetch byte 0.
  - Exit to S_RB_READY with spi_data_out = byte 0 valid on the first busy=0 cycle.
- S_RB_READY: busy=0.
  - r_byte=1: offset = (offset+1) mod 512, go to S_RB_BYTE.
  - r_block=0: go to S_IDLE.
- S_RB_BYTE:
  - busy=1 for BYTE_LATENCY and fetch the byte at the new offset.
  - Return to S_RB_READY only when latency has expired and r_byte=0. The new byte is valid when busy falls.
  - If r_block drops during S_RB_BYTE, finish the byte, then go to S_IDLE.
  - Net effect: after N byte requests, data_out = byte N mod 512, so the 512th request presents byte 0 again.
- S_WB_OPEN: busy=1 for BLOCK_LATENCY, then go to S_WB_READY.
- S_WB_READY: busy=0.
  - w_byte=1: go to S_WB_BYTE.
  - w_block=0: go to S_WB_COMMIT.
- S_WB_BYTE:
  - busy=1. On the first S_WB_BYTE cycle, capture spi_data_in and write it to mem[blk*512+offset] if offset<512 and in range; otherwise discard.
  - Because the capture is one cycle after w_byte is seen, a host-registered data_in is accepted.
  - offset saturates at 1023.
  - Return to S_WB_READY when latency has expired and w_byte=0.
- S_WB_COMMIT: busy=1 for COMMIT_LATENCY, then go to S_IDLE.
- Backdoor:
  - Serviced only in S_UNINIT and S_IDLE; ignored in other states.
  - bd_dout is updated the cycle after bd_addr is presented.
- Memory: single-port, byte-wide, 2^(BLK_ADDR_W+9) deep, synchronous read.

Decomposition:
- Package sdemu_pkg: state_t enum, SD_BLOCK_BYTES=512, default BASE_BLOCK.
- Sub-module: reuse memory_module (DATA_WIDTH 8, ADDR BLK_ADDR_W+9) for storage.
- One 16-bit latency down-counter inside the block.

Test Plan:
- Init: pulse spi_rst for 3 cycles → busy rises the next cycle, stays high for exactly 100 cycles after spi_rst falls, err=0.
- Read block:
  - Stimulus: backdoor-load block 0 with bytes 8'hAA,8'hBB,8'hCC,8'hDD,8'h03 then i[7:0]; r_block with addr 32'h0010_0000.
  - Response: busy pulses 8 cycles, data_out=8'hAA; successive r_byte handshakes give BB,CC,DD,03; the 512th request shows 8'hAA again.
- Write block:
  - Stimulus: w_block addr 32'h0010_0002; 516 w_byte handshakes with data = offset[7:0], data_in registered one cycle after w_byte.
  - Response: backdoor dump of block 2 shows byte k = k[7:0] for k<512; block 3 is untouched; busy stays high 16 cycles after w_block falls.
- Out of range: r_block with addr 32'h0010_0010 → err=1, data_out=8'hFF for every byte; a subsequent write to the same address leaves memory unchanged.
- Abort: assert spi_rst mid-write at offset 10 → immediate S_INIT; bytes 0..9 are kept, byte 10 is not; err cleared.
- Pre-init: r_block asserted in S_UNINIT → err=1, busy stays 0. Simultaneous r_block and w_block after init → read session opens.

Source files
------------

// File: rtl/sdemu_pkg.sv
// rtl/sdemu_pkg.sv - shared types and constants for the BRAM-backed SD SPI host emulator
package sdemu_pkg;

  typedef enum logic [3:0] {
    S_UNINIT,
    S_INIT,
    S_IDLE,
    S_RB_LOAD,
    S_RB_READY,
    S_RB_BYTE,
    S_WB_OPEN,
    S_WB_READY,
    S_WB_BYTE,
    S_WB_COMMIT
  } state_t;

  localparam int          SD_BLOCK_BYTES = 512;
  localparam logic [31:0] SD_BASE_BLOCK  = 32'h0010_0000;

  function automatic logic is_busy(input state_t s);
    return s inside {S_INIT, S_RB_LOAD, S_RB_BYTE, S_WB_OPEN, S_WB_BYTE, S_WB_COMMIT};
  endfunction

endpackage

// File: rtl/memory_module.sv
// rtl/memory_module.sv - single-port RAM with synchronous read (read-first)
module memory_module #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/sdspihost_bram_responder.sv
// rtl/sdspihost_bram_responder.sv - SD SPI host stand-in serving block reads/writes from BRAM
module sdspihost_bram_responder
  import sdemu_pkg::*;
#(
  parameter int          BLK_ADDR_W     = 4,
  parameter logic [31:0] BASE_BLOCK     = SD_BASE_BLOCK,
  parameter int          INIT_CYCLES    = 100,
  parameter int          BLOCK_LATENCY  = 8,
  parameter int          BYTE_LATENCY   = 2,
  parameter int          COMMIT_LATENCY = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    spi_rst,
  input  logic [31:0]             spi_block_addr,
  input  logic                    spi_r_block,
  input  logic                    spi_r_byte,
  input  logic                    spi_w_block,
  input  logic                    spi_w_byte,
  input  logic [7:0]              spi_data_in,
  output logic [7:0]              spi_data_out,
  output logic                    spi_busy,
  output logic                    spi_err,
  output logic                    spi_crc_err,
  input  logic                    crc_inject,
  input  logic                    bd_we,
  input  logic [BLK_ADDR_W+8:0]   bd_addr,
  input  logic [7:0]              bd_din,
  output logic [7:0]              bd_dout
);

  localparam int          AW         = BLK_ADDR_W + $clog2(SD_BLOCK_BYTES);
  localparam logic [15:0] INIT_LAT   = 16'(INIT_CYCLES);
  localparam logic [15:0] BLK_LAT    = 16'(BLOCK_LATENCY);
  localparam logic [15:0] BYTE_LAT   = 16'(BYTE_LATENCY);
  localparam logic [15:0] COMMIT_LAT = 16'(COMMIT_LATENCY);

  state_t                state, state_nx;
  logic [15:0]           cnt, cnt_nx;
  logic [9:0]            offset, offset_nx;
  logic [BLK_ADDR_W-1:0] blk;
  logic                  oor;
  logic                  err_set, wr_cap, rd_done, expired;
  logic [31:0]           blk_rel;
  logic                  addr_oor;
  logic                  bd_sel, bd_rd_q;
  logic [7:0]            bd_last;
  logic                  mem_we;
  logic [AW-1:0]         mem_addr;
  logic [7:0]            mem_din, mem_dout;

  assign blk_rel  = spi_block_addr - BASE_BLOCK;
  assign addr_oor = (spi_block_addr < BASE_BLOCK) || ((blk_rel >> BLK_ADDR_W) != 32'd0);
  assign expired  = (cnt <= 16'd1);

  always_comb begin
    state_nx  = state;
    cnt_nx    = (cnt > 16'd1) ? cnt - 16'd1 : cnt;
    offset_nx = offset;
    err_set   = 1'b0;
    wr_cap    = 1'b0;
    rd_done   = 1'b0;
    case (state)
      S_UNINIT:   if (spi_r_block || spi_w_block) err_set = 1'b1;
      S_INIT:     if (expired) state_nx = S_IDLE;
      S_IDLE: begin
        offset_nx = 10'd0;
        if (spi_r_block) begin
          state_nx = S_RB_LOAD;
          cnt_nx   = BLK_LAT;
          err_set  = addr_oor;
        end else if (spi_w_block) begin
          state_nx = S_WB_OPEN;
          cnt_nx   = BLK_LAT;
          err_set  = addr_oor;
        end
      end
      S_RB_LOAD:  if (expired) state_nx = S_RB_READY;
      S_RB_READY: begin
        if (spi_r_byte) begin
          offset_nx = {1'b0, offset[8:0] + 9'd1};
          cnt_nx    = BYTE_LAT;
          state_nx  = S_RB_BYTE;
        end else if (!spi_r_block) begin
          state_nx = S_IDLE;
        end
      end
      S_RB_BYTE: begin
        if (expired && !spi_r_byte) begin
          rd_done  = 1'b1;
          state_nx = spi_r_block ? S_RB_READY : S_IDLE;
        end
      end
      S_WB_OPEN:  if (expired) state_nx = S_WB_READY;
      S_WB_READY: begin
        if (spi_w_byte) begin
          cnt_nx   = BYTE_LAT;
          state_nx = S_WB_BYTE;
        end else if (!spi_w_block) begin
          cnt_nx   = COMMIT_LAT;
          state_nx = S_WB_COMMIT;
        end
      end
      S_WB_BYTE: begin
        // Counter still at its reload value only on the first cycle of the byte
        if (cnt == BYTE_LAT) begin
          wr_cap    = 1'b1;
          offset_nx = (offset == 10'd1023) ? offset : offset + 10'd1;
        end
        if (expired && !spi_w_byte) state_nx = S_WB_READY;
      end
      S_WB_COMMIT: if (expired) state_nx = S_IDLE;
      default:     state_nx = S_UNINIT;
    endcase
    if (spi_rst) begin
      state_nx  = S_INIT;
      cnt_nx    = INIT_LAT;
      offset_nx = 10'd0;
      wr_cap    = 1'b0;
      rd_done   = 1'b0;
    end
  end

  // Backdoor owns the RAM port whenever no session can be using it
  assign bd_sel   = (state == S_UNINIT) || (state == S_IDLE);
  assign mem_addr = bd_sel ? bd_addr : {blk, offset[8:0]};
  assign mem_din  = bd_sel ? bd_din : spi_data_in;
  assign mem_we   = bd_sel ? bd_we : (wr_cap && !oor && (offset < 10'(SD_BLOCK_BYTES)));

  memory_module #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(AW)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .din  (mem_din),
    .dout (mem_dout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_UNINIT;
      cnt          <= 16'd0;
      offset       <= 10'd0;
      blk          <= '0;
      oor          <= 1'b0;
      spi_err      <= 1'b0;
      spi_data_out <= 8'hFF;
      spi_crc_err  <= 1'b0;
      bd_rd_q      <= 1'b0;
      bd_last      <= 8'h00;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      offset <= offset_nx;
      if (state == S_IDLE) begin
        blk <= blk_rel[BLK_ADDR_W-1:0];
        oor <= addr_oor;
      end
      if (spi_rst) spi_err <= 1'b0;
      else if (err_set) spi_err <= 1'b1;
      // Tracks RAM output while busy; settles on the addressed byte before busy falls
      if (state == S_RB_LOAD || state == S_RB_BYTE) spi_data_out <= oor ? 8'hFF : mem_dout;
      spi_crc_err <= rd_done && crc_inject;
      bd_rd_q     <= bd_sel;
      bd_last     <= bd_dout;
    end
  end

  assign bd_dout  = bd_rd_q ? mem_dout : bd_last;
  assign spi_busy = is_busy(state);

endmodule

// File: tb/tb_sdspihost_bram_responder.sv
// tb/tb_sdspihost_bram_responder.sv - randomized self-checking bench for sdspihost_bram_responder
module tb_sdspihost_bram_responder;

  localparam logic [31:0] BASE = 32'h0010_0000;
  localparam int          WAIT_MAX = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_rst = 1'b0;
  logic [31:0] spi_block_addr = 32'd0;
  logic        spi_r_block = 1'b0, spi_r_byte = 1'b0;
  logic        spi_w_block = 1'b0, spi_w_byte = 1'b0;
  logic [7:0]  spi_data_in = 8'd0;
  logic [7:0]  spi_data_out;
  logic        spi_busy, spi_err, spi_crc_err;
  logic        crc_inject = 1'b0;
  logic        bd_we = 1'b0;
  logic [12:0] bd_addr = 13'd0;
  logic [7:0]  bd_din = 8'd0;
  logic [7:0]  bd_dout;

  always #5 clk = ~clk;

  sdspihost_bram_responder dut (
    .clk            (clk),
    .rst            (rst),
    .spi_rst        (spi_rst),
    .spi_block_addr (spi_block_addr),
    .spi_r_block    (spi_r_block),
    .spi_r_byte     (spi_r_byte),
    .spi_w_block    (spi_w_block),
    .spi_w_byte     (spi_w_byte),
    .spi_data_in    (spi_data_in),
    .spi_data_out   (spi_data_out),
    .spi_busy       (spi_busy),
    .spi_err        (spi_err),
    .spi_crc_err    (spi_crc_err),
    .crc_inject     (crc_inject),
    .bd_we          (bd_we),
    .bd_addr        (bd_addr),
    .bd_din         (bd_din),
    .bd_dout        (bd_dout)
  );

  // Card image as the host should see it: 16 blocks of 512 bytes
  logic [7:0] mdl [0:8191];
  logic [7:0] got [$];
  int         checks = 0;
  int         failures = 0;
  logic       chk_on = 1'b0, rd_chk = 1'b0;
  logic       exp_err = 1'b0, exp_crc = 1'b0;
  logic [7:0] exp_dout = 8'hFF;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    exp_crc = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("err_flag", int'(spi_err), int'(exp_err));
      check("crc_err", int'(spi_crc_err), int'(exp_crc));
      if (rd_chk && !spi_busy) check("rd_data", int'(spi_data_out), int'(exp_dout));
    end
  end

  // Count busy cycles from the current (busy) sample until busy drops
  task automatic wait_low(input string name, input logic crc, output int n);
    n = 0;
    while (spi_busy && n < WAIT_MAX) begin
      n++;
      tick();
    end
    check({name, "_bounded"}, int'(n < WAIT_MAX), 1);
    if (n < WAIT_MAX) exp_crc = crc;
  endtask

  function automatic bit addr_oor(input logic [31:0] addr);
    return (addr < BASE) || ((addr - BASE) >= 32'd16);
  endfunction

  task automatic read_session(input logic [31:0] addr, input int nbytes, input logic inj, input logic both);
    bit oor;
    int blk, n;
    oor = addr_oor(addr);
    blk = oor ? 0 : int'(addr - BASE);
    got.delete();
    spi_block_addr = addr;
    spi_r_block    = 1'b1;
    spi_w_block    = both;
    crc_inject     = inj;
    tick();
    if (oor) exp_err = 1'b1;
    wait_low("rb_open", 1'b0, n);
    check("rb_open_busy", n, 8);
    exp_dout = oor ? 8'hFF : mdl[blk*512];
    rd_chk = 1'b1;
    got.push_back(spi_data_out);
    for (int k = 1; k <= nbytes; k++) begin
      spi_r_byte = 1'b1;
      tick();
      check("rb_byte_busy", int'(spi_busy), 1);
      spi_r_byte = 1'b0;
      exp_dout = oor ? 8'hFF : mdl[blk*512 + (k % 512)];
      wait_low("rb_byte", inj, n);
      check("rb_byte_len", n, 2);
      got.push_back(spi_data_out);
    end
    rd_chk      = 1'b0;
    spi_r_block = 1'b0;
    spi_w_block = 1'b0;
    crc_inject  = 1'b0;
    tick();
  endtask

  task automatic write_session(input logic [31:0] addr, input int nbytes, input logic rnd, input int abort_at);
    bit oor;
    int blk, n;
    logic [7:0] d;
    oor = addr_oor(addr);
    blk = oor ? 0 : int'(addr - BASE);
    spi_block_addr = addr;
    spi_w_block    = 1'b1;
    tick();
    if (oor) exp_err = 1'b1;
    wait_low("wb_open", 1'b0, n);
    check("wb_open_busy", n, 8);
    for (int k = 0; k < nbytes; k++) begin
      if (k == abort_at) begin
        spi_w_block = 1'b0;
        spi_rst     = 1'b1;
        tick();
        exp_err = 1'b0;
        check("abort_busy", int'(spi_busy), 1);
        tick();
        tick();
        spi_rst = 1'b0;
        wait_low("abort_init", 1'b0, n);
        check("abort_init_busy", n, 100);
        return;
      end
      spi_w_byte = 1'b1;
      tick();
      check("wb_byte_busy", int'(spi_busy), 1);
      d = rnd ? 8'($urandom) : 8'(k);
      spi_w_byte  = 1'b0;
      spi_data_in = d;
      if (!oor && k < 512) mdl[blk*512 + k] = d;
      wait_low("wb_byte", 1'b0, n);
      check("wb_byte_len", n, 2);
    end
    spi_w_block = 1'b0;
    tick();
    wait_low("wb_commit", 1'b0, n);
    check("wb_commit_busy", n, 16);
  endtask

  task automatic dump(input int lo, input int hi, input string name);
    for (int a = lo; a < hi; a++) begin
      bd_addr = 13'(a);
      tick();
      check(name, int'(bd_dout), int'(mdl[a]));
    end
  endtask

  task automatic bd_lit(input int a, input int exp, input string name);
    bd_addr = 13'(a);
    tick();
    check(name, int'(bd_dout), exp);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int b;
    logic [7:0] d;

    tick();
    tick();
    check("rst_busy", int'(spi_busy), 0);
    check("rst_data_out", int'(spi_data_out), 'hFF);
    check("rst_err", int'(spi_err), 0);
    check("rst_crc_err", int'(spi_crc_err), 0);
    check("rst_bd_dout", int'(bd_dout), 0);
    rst = 1'b0;
    tick();
    chk_on = 1'b1;

    for (int a = 0; a < 8192; a++) begin
      if (a < 5) begin
        case (a)
          0: d = 8'hAA;
          1: d = 8'hBB;
          2: d = 8'hCC;
          3: d = 8'hDD;
          default: d = 8'h03;
        endcase
      end else if (a < 512) begin
        d = 8'(a);
      end else begin
        d = 8'($urandom);
      end
      mdl[a]  = d;
      bd_we   = 1'b1;
      bd_addr = 13'(a);
      bd_din  = d;
      tick();
    end
    bd_we = 1'b0;
    bd_lit(1, 'hBB, "bd_preload_lit");

    spi_r_block = 1'b1;
    tick();
    exp_err = 1'b1;
    check("preinit_busy", int'(spi_busy), 0);
    tick();
    check("preinit_busy_hold", int'(spi_busy), 0);
    spi_r_block = 1'b0;
    tick();

    spi_rst = 1'b1;
    tick();
    exp_err = 1'b0;
    check("init_busy_rise", int'(spi_busy), 1);
    tick();
    tick();
    spi_rst = 1'b0;
    wait_low("init", 1'b0, n);
    check("init_busy_len", n, 100);

    read_session(BASE, 512, 1'b0, 1'b0);
    check("rd_lit_b0", int'(got[0]), 'hAA);
    check("rd_lit_b1", int'(got[1]), 'hBB);
    check("rd_lit_b2", int'(got[2]), 'hCC);
    check("rd_lit_b3", int'(got[3]), 'hDD);
    check("rd_lit_b4", int'(got[4]), 'h03);
    check("rd_lit_b300", int'(got[300]), 'h2C);
    check("rd_lit_wrap", int'(got[512]), 'hAA);

    read_session(BASE + 32'd1, 6, 1'b1, 1'b0);

    write_session(BASE + 32'd2, 516, 1'b0, -1);
    bd_lit(2*512 + 7, 'h07, "wr_lit_7");
    bd_lit(2*512 + 200, 'hC8, "wr_lit_200");
    bd_lit(2*512 + 511, 'hFF, "wr_lit_511");
    dump(2*512, 4*512, "wr_dump_b2_b3");

    read_session(BASE + 32'd16, 20, 1'b0, 1'b0);
    check("oor_lit_first", int'(got[0]), 'hFF);
    check("oor_lit_last", int'(got[20]), 'hFF);
    check("oor_err_lit", int'(spi_err), 1);
    write_session(BASE + 32'd16, 8, 1'b1, -1);
    read_session(BASE - 32'd1, 3, 1'b0, 1'b0);

    write_session(BASE + 32'd5, 20, 1'b1, 10);
    check("abort_err_lit", int'(spi_err), 0);
    dump(5*512, 5*512 + 16, "abort_dump");

    read_session(BASE + 32'd4, 3, 1'b0, 1'b1);

    for (int s = 0; s < 10; s++) begin
      b = int'($urandom_range(0, 17));
      if ($urandom_range(0, 1) == 0)
        read_session(BASE + 32'(b), int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)), 1'b0);
      else
        write_session(BASE + 32'(b), int'($urandom_range(1, 40)), 1'b1, -1);
    end

    dump(0, 8192, "final_dump");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
